// File: rtl/serial_adder.sv
// Bit-serial, LSB-first WIDTH-bit adder with a start/busy/done handshake.
// Each bit is formed by two half adders and a registered carry.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] partial_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic s0_s;
    logic c0_s;
    logic s1_s;
    logic c1_s;
    logic carry_nxt_s;

    half_adder u_ha0 (
        .a (a_sr_r[0]),
        .b (b_sr_r[0]),
        .s (s0_s),
        .c (c0_s)
    );

    half_adder u_ha1 (
        .a (s0_s),
        .b (carry_r),
        .s (s1_s),
        .c (c1_s)
    );

    assign carry_nxt_s = c0_s | c1_s;

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

    // Control FSM, operand/partial shift registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            a_sr_r    <= {WIDTH{1'b0}};
            b_sr_r    <= {WIDTH{1'b0}};
            partial_r <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            count_r   <= {CW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sum_r     <= {WIDTH{1'b0}};
            cout_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sr_r    <= a;
                        b_sr_r    <= b;
                        partial_r <= {WIDTH{1'b0}};
                        carry_r   <= 1'b0;
                        count_r   <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_ADD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
                    partial_r <= {s1_s, partial_r[WIDTH-1:1]};
                    carry_r   <= carry_nxt_s;
                    count_r   <= count_r + CNT_ONE;
                    busy_r    <= 1'b1;
                    if (count_r == CNT_LAST) begin
                        // Final bit: the shifted partial plus this bit is the full sum.
                        sum_r   <= {s1_s, partial_r[WIDTH-1:1]};
                        cout_r  <= carry_nxt_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= ST_ADD;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, scoreboard queue and
// hand-written sequences for reset abort and back-to-back operation.

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    logic [W:0] sb_q[$];
    logic [W:0] model_r;
    logic [W:0] pop_v;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        int           mode;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[9];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop on done, otherwise the result must hold its last value.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            model_r <= '0;
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end else if (done) begin
            done_cnt <= done_cnt + 1;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                pop_v = sb_q.pop_front();
                check("sb_sum", 32'(sum), 32'(pop_v[W-1:0]));
                check("sb_cout", 32'(cout), 32'(pop_v[W]));
                model_r <= pop_v;
            end
        end else begin
            check("hold_result", 32'({cout, sum}), 32'(model_r));
        end
    end

    // mode 0: plain; 1: operands change mid-ADD; 2: extra start pulses at edges k+3, k+8.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W:0] exp, input int mode,
                          output int lat, output int bcnt);
        @(posedge clk); #2;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (mode == 1 && lat == 3) begin
                a = '0;
                b = '0;
            end
            if (mode == 2 && (lat == 2 || lat == 7)) start = 1'b1;
            if (mode == 2 && (lat == 3 || lat == 8)) start = 1'b0;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        if (busy) bcnt++;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 30);
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int bcnt;
        int d0;

        vecs[0] = '{8'h00, 8'h00, 0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 2, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 0, 8'hFE, 1'b1};
        vecs[6] = '{8'hC8, 8'h64, 0, 8'h2C, 1'b1};
        vecs[7] = '{8'h3C, 8'h0F, 0, 8'h4B, 1'b0};
        vecs[8] = '{8'h01, 8'hFE, 0, 8'hFF, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_sum", 32'({cout, sum}), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            d0 = done_cnt;
            run_op(vecs[i].va, vecs[i].vb, {vecs[i].exp_cout, vecs[i].exp_sum},
                   vecs[i].mode, lat, bcnt);
            check($sformatf("latency[%0d]", i), 32'(lat), 32'd8);
            check($sformatf("busy_cycles[%0d]", i), 32'(bcnt), 32'd9);
            check($sformatf("done_count[%0d]", i), 32'(done_cnt - d0), 32'd1);
        end

        // Reset four cycles into ADD aborts the operation.
        @(posedge clk); #2;
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        d0    = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'({cout, sum}), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_op(8'h12, 8'h34, {1'b0, 8'h46}, 0, lat, bcnt);
        check("post_abort_latency", 32'(lat), 32'd8);

        // Back-to-back with start held high: one result every WIDTH+2 cycles.
        @(posedge clk); #2;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        d0    = done_cnt;
        for (int i = 0; i < 3; i++) sb_q.push_back({1'b0, 8'h02});
        @(posedge clk);
        wait_done(lat);
        check("b2b_first", 32'(lat), 32'd8);
        wait_done(lat);
        check("b2b_interval1", 32'(lat), 32'd10);
        wait_done(lat);
        check("b2b_interval2", 32'(lat), 32'd10);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
        check("b2b_idle", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
